jugador_auto: RTL and testbench

JUGADOR_AUTO -- requirements
Module: jugador_auto

---
 rtl/jugador_auto_if.sv | 29 ++
 rtl/jugador_auto.sv | 187 ++++++++++++++++++
 tb/tb_jugador_auto.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/jugador_auto_if.sv
// Bundle of request, cursor feedback and button lines between the
// auto-player and whatever drives it (game model or host).
interface jugador_auto_if;
  logic       start;
  logic [2:0] target_x;
  logic [2:0] target_y;
  logic [2:0] posicion_x;
  logic [2:0] posicion_y;
  logic       izquierda;
  logic       derecha;
  logic       arriba;
  logic       abajo;
  logic       attack;
  logic       busy;
  logic       done;
  logic       error;

  // Requester / game side
  modport master (
    output start, target_x, target_y, posicion_x, posicion_y,
    input  izquierda, derecha, arriba, abajo, attack, busy, done, error
  );

  // Auto-player side
  modport slave (
    input  start, target_x, target_y, posicion_x, posicion_y,
    output izquierda, derecha, arriba, abajo, attack, busy, done, error
  );
endinterface

// File: rtl/jugador_auto.sv
// Auto-player: walks the game cursor to a target cell by pulsing the
// active-low direction buttons one at a time, then pulses attack.
// Aborts with an error pulse when the move budget is exhausted.
module jugador_auto #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_MOVES    = 16
) (
  input  logic          clk,
  input  logic          reset,
  jugador_auto_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMPARE  = 3'd1;
  localparam logic [2:0] S_PRESS    = 3'd2;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_FIRE     = 3'd4;
  localparam logic [2:0] S_FIRE_REL = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  // Counter reload values: the state lasts (load + 1) cycles.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] MOVE_LIMIT = 8'(MAX_MOVES);

  // Direction codes double as bit positions in the button vector.
  localparam logic [1:0] D_IZQ = 2'd0;
  localparam logic [1:0] D_DER = 2'd1;
  localparam logic [1:0] D_ARR = 2'd2;
  localparam logic [1:0] D_ABA = 2'd3;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] moves_q, moves_d;
  logic [2:0] tx_q, tx_d;
  logic [2:0] ty_q, ty_d;
  logic [1:0] dir_q, dir_d;
  // Active-low buttons: [0] izquierda, [1] derecha, [2] arriba, [3] abajo, [4] attack
  logic [4:0] btn_q, btn_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  // Next-state, counter and target-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moves_d = moves_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_d    = bus.target_x;
          ty_d    = bus.target_y;
          moves_d = 8'd0;
          cnt_d   = 8'd0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (bus.posicion_x == tx_q && bus.posicion_y == ty_q) begin
          cnt_d   = PULSE_LOAD;
          state_d = S_FIRE;
        end else if (moves_q == MOVE_LIMIT) begin
          // A cursor that never reaches the target ends here.
          cnt_d   = 8'd0;
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          if (bus.posicion_x > tx_q) begin
            dir_d = D_IZQ;
          end else if (bus.posicion_x < tx_q) begin
            dir_d = D_DER;
          end else if (bus.posicion_y > ty_q) begin
            dir_d = D_ARR;
          end else begin
            dir_d = D_ABA;
          end
          // The move is counted once, as the press begins.
          moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          cnt_d   = PULSE_LOAD;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd0;
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FIRE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_FIRE_REL;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FIRE_REL: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FIN: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Button and busy values decoded from the next state so the flops
  // change exactly on state entry, never glitching.
  always_comb begin
    btn_d = 5'b11111;
    if (state_d == S_PRESS) begin
      case (dir_d)
        D_IZQ:   btn_d[0] = 1'b0;
        D_DER:   btn_d[1] = 1'b0;
        D_ARR:   btn_d[2] = 1'b0;
        default: btn_d[3] = 1'b0;
      endcase
    end else if (state_d == S_FIRE) begin
      btn_d[4] = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset releases every button at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      moves_q <= 8'd0;
      tx_q    <= 3'd0;
      ty_q    <= 3'd0;
      dir_q   <= 2'd0;
      btn_q   <= 5'b11111;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moves_q <= moves_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      dir_q   <= dir_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.izquierda = btn_q[0];
  assign bus.derecha   = btn_q[1];
  assign bus.arriba    = btn_q[2];
  assign bus.abajo     = btn_q[3];
  assign bus.attack    = btn_q[4];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_jugador_auto.sv
// Bench for jugador_auto: a game model moves the cursor on each button
// press; every shot is compared with a press list derived from the
// target distance and move limit.
module tb_jugador_auto;
  localparam int P = 4;
  localparam int G = 4;
  localparam int M = 16;

  logic clk;
  logic reset;
  jugador_auto_if bus ();

  jugador_auto #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .MAX_MOVES(M)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Game model and press-event log
  int gx, gy;
  bit frozen;
  int cyc;
  int run, cur_id, gap_run, pend_gap;
  int ev_n;
  int ev_id [64];
  int ev_len[64];
  int ev_gap[64];
  int done_cnt, err_cnt, done_cyc, err_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_event();
    if (ev_n < 64) begin
      ev_id[ev_n]  = cur_id;
      ev_len[ev_n] = run;
      ev_gap[ev_n] = pend_gap;
      ev_n++;
    end
  endtask

  // One clock: sample at the falling edge, run monitor and game model.
  task automatic tick();
    logic [4:0] low;
    int id;
    @(negedge clk);
    cyc++;
    low = ~{bus.attack, bus.abajo, bus.arriba, bus.derecha, bus.izquierda};
    check("onehot", ($countones(low) <= 1) ? 1 : 0, 1);
    if (low != 5'd0) begin
      id = 0;
      for (int i = 4; i >= 0; i--) if (low[i]) id = i;
      if (run > 0 && id == cur_id) begin
        run++;
      end else begin
        if (run > 0) push_event();
        cur_id   = id;
        run      = 1;
        pend_gap = gap_run;
        if (!frozen) begin
          case (id)
            0: if (gx > 0) gx--;
            1: if (gx < 7) gx++;
            2: if (gy > 0) gy--;
            3: if (gy < 7) gy++;
            default: ;
          endcase
          bus.posicion_x = 3'(gx);
          bus.posicion_y = 3'(gy);
        end
      end
    end else begin
      if (run > 0) begin
        push_event();
        run     = 0;
        gap_run = 1;
      end else begin
        gap_run++;
      end
    end
    if (bus.done)  begin done_cnt++; done_cyc = cyc; end
    if (bus.error) begin err_cnt++;  err_cyc  = cyc; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 3000) begin tick(); k++; end
    check("idle_wait", bus.busy ? 1 : 0, 0);
  endtask

  task automatic run_shot(input int sx, input int sy, input int tx, input int ty,
                          input bit frz, input bit hold);
    int dx, dy, k, n;
    bit fire;
    int exp_id[$];
    wait_idle();
    frozen = frz;
    gx = sx; gy = sy;
    bus.posicion_x = 3'(sx);
    bus.posicion_y = 3'(sy);
    run = 0; gap_run = 0; pend_gap = 0; ev_n = 0;
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    bus.start    = 1'b1;
    bus.target_x = 3'(tx);
    bus.target_y = 3'(ty);
    cyc = 0;  // this IDLE cycle is cycle 0
    tick();
    check("accept_busy", bus.busy ? 1 : 0, 1);
    if (!hold) bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 3000) begin
      if (hold) begin
        bus.target_x = 3'($urandom_range(0, 7));
        bus.target_y = 3'($urandom_range(0, 7));
      end
      tick();
      k++;
    end
    check("shot_timeout", bus.busy ? 1 : 0, 0);
    bus.start = 1'b0;

    // Reference: X moves first, then Y; a frozen cursor repeats its
    // first move until the budget is spent.
    dx = tx - sx;
    dy = ty - sy;
    if (frz && (dx != 0 || dy != 0)) begin
      repeat (M) exp_id.push_back(dx < 0 ? 0 : (dx > 0 ? 1 : (dy < 0 ? 2 : 3)));
      fire = 1'b0;
    end else begin
      repeat (dx < 0 ? -dx : dx) exp_id.push_back(dx < 0 ? 0 : 1);
      repeat (dy < 0 ? -dy : dy) exp_id.push_back(dy < 0 ? 2 : 3);
      fire = 1'b1;
      while (exp_id.size() > M) begin void'(exp_id.pop_back()); fire = 1'b0; end
    end
    n = exp_id.size();
    if (fire) exp_id.push_back(4);

    check("event_count", ev_n, exp_id.size());
    for (int i = 0; i < ev_n && i < exp_id.size(); i++) begin
      check("button_id", ev_id[i], exp_id[i]);
      check("low_len", ev_len[i], P);
      // High run between presses covers RELEASE plus the COMPARE cycle.
      if (i > 0) check("gap_len", ev_gap[i], G + 1);
    end
    check("done_count", done_cnt, fire ? 1 : 0);
    check("error_count", err_cnt, fire ? 0 : 1);
    if (fire) check("done_cycle", done_cyc, (n + 1) * (P + G + 1) + 1);
    else      check("error_cycle", err_cyc, n * (P + G + 1) + 2);
    if (!frz) begin
      check("final_x", gx, tx);
      check("final_y", gy, ty);
    end
    $display("shot (%0d,%0d)->(%0d,%0d) frozen=%0d hold=%0d moves=%0d fire=%0d events=%0d",
             sx, sy, tx, ty, frz, hold, n, fire, ev_n);
  endtask

  initial begin
    int k;
    reset          = 1'b1;
    frozen         = 1'b0;
    bus.start      = 1'b0;
    bus.target_x   = 3'd0;
    bus.target_y   = 3'd0;
    bus.posicion_x = 3'd0;
    bus.posicion_y = 3'd0;
    run = 0; gap_run = 0; pend_gap = 0; ev_n = 0; cyc = 0;
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    gx = 0; gy = 0; cur_id = 0;
    repeat (2) @(negedge clk);
    check("rst_buttons", {27'd0, bus.attack, bus.abajo, bus.arriba, bus.derecha, bus.izquierda}, 31);
    check("rst_busy", bus.busy ? 1 : 0, 0);
    check("rst_done", bus.done ? 1 : 0, 0);
    check("rst_error", bus.error ? 1 : 0, 0);
    reset = 1'b0;
    tick();

    // Directed scenarios
    run_shot(5, 5, 3, 4, 1'b0, 1'b0);
    run_shot(2, 2, 2, 2, 1'b0, 1'b0);
    run_shot(0, 0, 7, 0, 1'b1, 1'b0);
    run_shot(6, 1, 1, 6, 1'b0, 1'b1);

    // Reset during the second low cycle of a derecha press
    wait_idle();
    frozen = 1'b1;
    bus.posicion_x = 3'd0;
    bus.posicion_y = 3'd0;
    bus.target_x   = 3'd7;
    bus.target_y   = 3'd0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (bus.derecha && k < 50) begin tick(); k++; end
    check("derecha_seen", bus.derecha ? 1 : 0, 0);
    tick();
    check("derecha_2nd", bus.derecha ? 1 : 0, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_derecha", bus.derecha ? 1 : 0, 1);
    check("midrst_busy", bus.busy ? 1 : 0, 0);
    check("midrst_buttons", {27'd0, bus.attack, bus.abajo, bus.arriba, bus.derecha, bus.izquierda}, 31);
    tick();
    reset = 1'b0;
    $display("reset during derecha press applied");
    run_shot(0, 3, 4, 1, 1'b0, 1'b0);

    // Randomized shots
    for (int s = 0; s < 12; s++) begin
      run_shot($urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
